// File: rtl/spi_slave_frontend.sv
// Slave-side serial front end: collects a {message, key} frame from mosi, starts the
// cipher core, then returns the core result on miso with a per-bit valid.
module spi_slave_frontend #(
  parameter int NK = 4,
  parameter int NB = 4,
  parameter int KEY_W = 32 * NK,
  parameter int MSG_W = 32 * NB,
  parameter int FRAME_W = MSG_W + KEY_W
) (
  input  logic             in_clk,
  input  logic             rst,
  input  logic             cs_n,
  input  logic             mosi,
  input  logic             in_valid,
  output logic             miso,
  output logic             out_valid,
  output logic [MSG_W-1:0] msg_out,
  output logic [KEY_W-1:0] key_out,
  output logic             core_start,
  input  logic             core_done,
  input  logic [MSG_W-1:0] core_result,
  output logic             busy,
  output logic             frame_err
);

  // state | meaning
  // IDLE  | waiting for cs_n low
  // RECV  | shifting in the frame from mosi
  // WAIT  | core running, waiting for core_done
  // SEND  | shifting the result out on miso
  typedef enum logic [1:0] {IDLE, RECV, WAIT, SEND} state_t;

  localparam int CNT_W = $clog2(FRAME_W + 1);
  localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] MSG_CNT   = CNT_W'(MSG_W);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t             state;
  logic [CNT_W-1:0]   bit_cnt;
  logic [FRAME_W-1:0] rx_sr;
  logic [MSG_W-1:0]   tx_sr;

  always_ff @(posedge in_clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      rx_sr      <= '0;
      tx_sr      <= '0;
      miso       <= 1'b0;
      out_valid  <= 1'b0;
      msg_out    <= '0;
      key_out    <= '0;
      core_start <= 1'b0;
      busy       <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      core_start <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        IDLE: begin
          miso      <= 1'b0;
          out_valid <= 1'b0;
          if (!cs_n) begin
            state <= RECV;
            busy  <= 1'b1;
            if (in_valid) begin
              rx_sr   <= {rx_sr[FRAME_W-2:0], mosi};
              bit_cnt <= CNT_ONE;
            end else begin
              bit_cnt <= '0;
            end
          end else begin
            busy <= 1'b0;
          end
        end
        RECV: begin
          if (bit_cnt == FRAME_CNT) begin
            // Frame complete: a late cs_n rise no longer counts as an abort.
            msg_out    <= rx_sr[FRAME_W-1:KEY_W];
            key_out    <= rx_sr[KEY_W-1:0];
            core_start <= 1'b1;
            state      <= WAIT;
          end else if (cs_n) begin
            frame_err <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end else if (in_valid) begin
            rx_sr   <= {rx_sr[FRAME_W-2:0], mosi};
            bit_cnt <= bit_cnt + CNT_ONE;
          end
        end
        WAIT: begin
          if (core_done) begin
            tx_sr   <= core_result;
            bit_cnt <= '0;
            state   <= SEND;
          end
        end
        SEND: begin
          if (bit_cnt == MSG_CNT) begin
            miso      <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            miso      <= tx_sr[MSG_W-1];
            out_valid <= 1'b1;
            tx_sr     <= {tx_sr[MSG_W-2:0], 1'b0};
            bit_cnt   <= bit_cnt + CNT_ONE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave_frontend.sv
// Directed bench for spi_slave_frontend: table of frames plus abort, reset and
// spurious-done sequences, all with hand-computed expectations.
module tb_spi_slave_frontend;

  localparam int MSG_W = 128;
  localparam int KEY_W = 128;
  localparam int FRAME_W = 256;

  logic             in_clk = 1'b0;
  logic             rst = 1'b1;
  logic             cs_n = 1'b1;
  logic             mosi = 1'b0;
  logic             in_valid = 1'b0;
  logic             miso;
  logic             out_valid;
  logic [MSG_W-1:0] msg_out;
  logic [KEY_W-1:0] key_out;
  logic             core_start;
  logic             core_done = 1'b0;
  logic [MSG_W-1:0] core_result = '0;
  logic             busy;
  logic             frame_err;

  int checks = 0;
  int failures = 0;

  spi_slave_frontend dut (
    .in_clk(in_clk), .rst(rst), .cs_n(cs_n), .mosi(mosi), .in_valid(in_valid),
    .miso(miso), .out_valid(out_valid), .msg_out(msg_out), .key_out(key_out),
    .core_start(core_start), .core_done(core_done), .core_result(core_result),
    .busy(busy), .frame_err(frame_err)
  );

  always #5 in_clk = ~in_clk;

  typedef struct {
    logic [MSG_W-1:0] msg;
    logic [KEY_W-1:0] key;
    logic [MSG_W-1:0] result;
    bit               gapped;
  } vec_t;

  vec_t vecs[3];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge in_clk);
    #1;
  endtask

  // Shifts a frame in and checks the parallel hand-off one cycle after the last bit.
  task automatic send_frame(input logic [MSG_W-1:0] msg, input logic [KEY_W-1:0] key,
                            input bit gapped);
    logic [FRAME_W-1:0] frame;
    int early_start;
    frame = {msg, key};
    early_start = 0;
    cs_n = 1'b0;
    for (int i = 0; i < FRAME_W; i++) begin
      if (gapped && i > 0 && (i % 8) == 0) begin
        in_valid = 1'b0;
        mosi = ~mosi;
        for (int g = 0; g < 3; g++) begin
          tick();
          if (core_start) early_start++;
        end
      end
      in_valid = 1'b1;
      mosi = frame[FRAME_W-1-i];
      tick();
      if (core_start) early_start++;
    end
    in_valid = 1'b0;
    mosi = 1'b0;
    chk("no_early_start", 256'(early_start), 256'd0);
    tick();
    chk("core_start", 256'(core_start), 256'd1);
    chk("busy_wait", 256'(busy), 256'd1);
    chk("msg_out", 256'(msg_out), 256'(msg));
    chk("key_out", 256'(key_out), 256'(key));
    cs_n = 1'b1;
    tick();
    chk("core_start_once", 256'(core_start), 256'd0);
  endtask

  // Returns a result through the core handshake and checks the serial stream.
  task automatic return_result(input logic [MSG_W-1:0] res);
    int bad_bits;
    int bad_valid;
    bad_bits = 0;
    bad_valid = 0;
    core_done = 1'b1;
    core_result = res;
    tick();
    core_done = 1'b0;
    core_result = '0;
    chk("ov_latency", 256'(out_valid), 256'd0);
    for (int i = 0; i < MSG_W; i++) begin
      tick();
      if (out_valid !== 1'b1) bad_valid++;
      if (miso !== res[MSG_W-1-i]) bad_bits++;
    end
    chk("ov_width", 256'(bad_valid), 256'd0);
    chk("miso_bits", 256'(bad_bits), 256'd0);
    tick();
    chk("ov_end", 256'(out_valid), 256'd0);
    chk("miso_end", 256'(miso), 256'd0);
    chk("busy_end", 256'(busy), 256'd0);
  endtask

  initial begin
    vecs[0] = '{msg: 128'h00112233445566778899aabbccddeeff,
                key: 128'h000102030405060708090a0b0c0d0e0f,
                result: 128'h69c4e0d86a7b0430d8cdb78070b4c55a, gapped: 1'b0};
    vecs[1] = '{msg: 128'h00112233445566778899aabbccddeeff,
                key: 128'h000102030405060708090a0b0c0d0e0f,
                result: 128'h8000000000000000000000000000_0001, gapped: 1'b1};
    vecs[2] = '{msg: 128'hdeadbeef_0badf00d_12345678_9abcdef0,
                key: 128'hffffffff_00000000_a5a5a5a5_5a5a5a5a,
                result: 128'hf0f0f0f0_0f0f0f0f_cafebabe_00000000, gapped: 1'b0};

    #1;
    chk("rst_miso", 256'(miso), 256'd0);
    chk("rst_ov", 256'(out_valid), 256'd0);
    chk("rst_msg", 256'(msg_out), 256'd0);
    chk("rst_key", 256'(key_out), 256'd0);
    chk("rst_busy", 256'(busy), 256'd0);
    chk("rst_start", 256'(core_start), 256'd0);
    chk("rst_err", 256'(frame_err), 256'd0);
    tick();
    rst = 1'b0;
    tick();

    for (int v = 0; v < 2; v++) begin
      send_frame(vecs[v].msg, vecs[v].key, vecs[v].gapped);
      return_result(vecs[v].result);
    end

    // Abort after 100 bits: outputs must keep the previous frame.
    cs_n = 1'b0;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1;
      mosi = vecs[2].msg[MSG_W-1-(i % MSG_W)];
      tick();
    end
    in_valid = 1'b0;
    cs_n = 1'b1;
    tick();
    chk("abort_err", 256'(frame_err), 256'd1);
    chk("abort_start", 256'(core_start), 256'd0);
    chk("abort_busy", 256'(busy), 256'd0);
    chk("abort_msg", 256'(msg_out), 256'(vecs[1].msg));
    chk("abort_key", 256'(key_out), 256'(vecs[1].key));
    tick();
    chk("abort_err_once", 256'(frame_err), 256'd0);
    chk("abort_start2", 256'(core_start), 256'd0);

    send_frame(vecs[2].msg, vecs[2].key, 1'b0);
    return_result(vecs[2].result);

    // Reset in SEND after 40 bits.
    send_frame(vecs[0].msg, vecs[0].key, 1'b0);
    core_done = 1'b1;
    core_result = vecs[0].result;
    tick();
    core_done = 1'b0;
    for (int i = 0; i < 40; i++) tick();
    chk("pre_rst_ov", 256'(out_valid), 256'd1);
    rst = 1'b1;
    #1;
    chk("arst_ov", 256'(out_valid), 256'd0);
    chk("arst_miso", 256'(miso), 256'd0);
    chk("arst_busy", 256'(busy), 256'd0);
    chk("arst_msg", 256'(msg_out), 256'd0);
    tick();
    chk("arst_err", 256'(frame_err), 256'd0);
    chk("arst_start", 256'(core_start), 256'd0);
    rst = 1'b0;
    tick();
    send_frame(vecs[2].msg, vecs[2].key, 1'b0);
    return_result(vecs[2].result);

    // Spurious core_done in IDLE and RECV.
    core_done = 1'b1;
    core_result = vecs[0].result;
    for (int i = 0; i < 3; i++) tick();
    chk("spur_idle_ov", 256'(out_valid), 256'd0);
    chk("spur_idle_busy", 256'(busy), 256'd0);
    cs_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      mosi = 1'b1;
      tick();
    end
    chk("spur_recv_ov", 256'(out_valid), 256'd0);
    chk("spur_recv_busy", 256'(busy), 256'd1);
    core_done = 1'b0;
    in_valid = 1'b0;
    cs_n = 1'b1;
    tick();
    chk("spur_abort_err", 256'(frame_err), 256'd1);
    tick();
    chk("spur_end_ov", 256'(out_valid), 256'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_slave_frontend.md
Name: spi_slave_frontend

Overview:
- Serial front-end on the encryption/decryption side of the link, directly downstream of the serial master.
- Deserialises the {message, key} frame the master shifts out on mosi while chip-select is low.
- Presents the message and key in parallel to the cipher core with a one-cycle start pulse.
- Waits for the core's done signal, then serialises the result back to the master on miso with a per-bit valid.

Parameters:
- NK, 4, key length in 32-bit words; KEY_W = 32*NK.
- NB, 4, block length in 32-bit columns; MSG_W = 32*NB.
- Derived: FRAME_W = MSG_W + KEY_W (default 256 bits).

Ports:
- in_clk  input  1  clock, shared with the master (master out_clk).
- rst  input  1  reset, asynchronous, active-high.
- cs_n  input  1  chip select, active-low (master cs_enc_dec).
- mosi  input  1  serial data from the master, MSB of the frame first.
- in_valid  input  1  mosi bit valid this cycle (master out_valid).
- miso  output  1  serial result to the master, MSB first.
- out_valid  output  1  miso bit valid this cycle (master in_valid).
- msg_out  output  MSG_W  latched message to the core.
- key_out  output  KEY_W  latched key to the core.
- core_start  output  1  one-cycle start pulse to the core.
- core_done  input  1  core result valid; level or pulse.
- core_result  input  MSG_W  processed block from the core.
- busy  output  1  high in every state except IDLE.
- frame_err  output  1  one-cycle pulse when a frame is aborted.

Behaviour:
- Reset values: miso=0, out_valid=0, msg_out=0, key_out=0, core_start=0, busy=0, frame_err=0, bit counter=0, shift registers=0, state=IDLE.
- Reset mid-operation aborts everything immediately. No core_start or frame_err is produced by the reset itself.
- All outputs are registered and update on the posedge of in_clk.
- IDLE:
  - If cs_n=0, go to RECV and clear the counter.
  - If in_valid=1 in that same cycle, that bit is also captured and the counter becomes 1.
- RECV:
  - On each cycle with cs_n=0 and in_valid=1: rx_sr <= {rx_sr[FRAME_W-2:0], mosi}; bit_cnt increments.
  - Cycles with in_valid=0 hold rx_sr and bit_cnt; gaps are allowed.
  - When the bit that makes bit_cnt = FRAME_W is captured, the next edge latches msg_out = rx_sr[FRAME_W-1:KEY_W] and key_out = rx_sr[KEY_W-1:0], asserts core_start=1 for exactly one cycle, and goes to WAIT.
  - If cs_n=1 while bit_cnt < FRAME_W: discard the frame, pulse frame_err for one cycle, go to IDLE. msg_out and key_out keep their old values.
  - Bits arriving with in_valid=1 after the count is reached are ignored.
- WAIT:
  - core_done=1 latches tx_sr <= core_result and goes to SEND.
  - cs_n and in_valid are ignored.
  - core_done seen in any state other than WAIT is ignored.
- SEND:
  - On each of MSG_W consecutive cycles: out_valid=1, miso=tx_sr[MSG_W-1], then tx_sr shifts left by one.
  - No gaps are inserted. The first valid bit appears one cycle after core_done was sampled.
  - After the MSG_W-th bit, the next edge sets out_valid=0 and miso=0 and goes to IDLE.
  - cs_n is ignored during SEND.
  - miso is 0 whenever out_valid=0; the slave never drives Z.
- Back-to-back frames: after returning to IDLE, a new low on cs_n starts a new frame. A new frame needs no extra idle cycle beyond that return transition.
- Latency, with the core's own latency excluded:
  - Last mosi bit to core_start: 1 cycle.
  - core_done to first out_valid: 1 cycle.
  - First out_valid to last bit: MSG_W-1 cycles.
- Width rules: bit_cnt is wide enough for FRAME_W, 9 bits at the defaults. The counter saturates and does not wrap.

Test Plan:
- Full frame, no gaps: msg=128'h00112233445566778899aabbccddeeff, key=128'h000102030405060708090a0b0c0d0e0f, in_valid high for 256 cycles -> msg_out/key_out match exactly; core_start high for 1 cycle, 1 cycle after the last bit; busy=1.
- Result return: core_done with core_result=128'h69c4e0d86a7b0430d8cdb78070b4c55a -> out_valid high for exactly 128 cycles starting 1 cycle later; miso reproduces the value MSB first; then IDLE with miso=0 and out_valid=0.
- Gapped input: in_valid deasserted for 3 cycles every 8 bits, same frame -> identical msg_out/key_out; core_start fires only after bit 256.
- Abort: cs_n rises after 100 bits -> frame_err for 1 cycle; no core_start; msg_out/key_out unchanged; a following full frame is accepted correctly.
- Reset in SEND after 40 bits -> out_valid=0, miso=0, busy=0 immediately; a subsequent frame works.
- Spurious core_done in IDLE and RECV -> no SEND entry; out_valid stays 0.
